// File: rtl/vector_regfile.sv
// Vector register file: NREGS registers of LANES x LW bits, two combinational
// read ports with write-through bypass, one masked/splatting write port, a
// per-register pending scoreboard and a multi-cycle bulk clear sequencer.
module vector_regfile #(
   parameter  int NREGS = 4,
   parameter  int LANES = 4,
   parameter  int LW    = 8,
   localparam int RW    = $clog2(NREGS),
   localparam int VW    = LANES * LW
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [RW-1:0]    vreg1,
   input  logic [RW-1:0]    vreg2,
   output logic [VW-1:0]    vdata1,
   output logic [VW-1:0]    vdata2,
   input  logic [RW-1:0]    vregw,
   input  logic [VW-1:0]    vdataw,
   input  logic [LANES-1:0] vmask,
   input  logic             VRFWrite,
   input  logic             vsplat,
   input  logic [RW-1:0]    vregr,
   input  logic             VRFReserve,
   output logic             busy1,
   output logic             busy2,
   input  logic             VRFClear,
   output logic             clearing
);

   typedef enum logic {IDLE = 1'b0, CLR = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [RW-1:0]     cnt_reg, cnt_next;
   logic [VW-1:0]     regs_reg [NREGS];
   logic [NREGS-1:0]  pend_reg;

   logic [VW-1:0]     wval;
   logic [VW-1:0]     lane_en;
   logic [VW-1:0]     merged;
   logic              wr_acc;
   logic              rsv_acc;
   logic              byp_en;
   logic              hit1, hit2;

   assign clearing = (state_reg == CLR);
   assign wr_acc   = VRFWrite & ~clearing;
   assign rsv_acc  = VRFReserve & ~clearing;
   // The bypass must stay dark while reset is held so the read ports show zeros.
   assign byp_en   = wr_acc & reset;

   // Per-lane write value (optionally splatted from lane 0) and lane enables.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign wval[gi*LW +: LW]    = vsplat ? vdataw[LW-1:0] : vdataw[gi*LW +: LW];
         assign lane_en[gi*LW +: LW] = {LW{vmask[gi]}};
      end
   endgenerate

   assign merged = (regs_reg[vregw] & ~lane_en) | (wval & lane_en);

   assign hit1   = byp_en && (vregw == vreg1);
   assign hit2   = byp_en && (vregw == vreg2);

   // Read ports: a register being written this cycle shows the merged value.
   assign vdata1 = hit1 ? ((regs_reg[vreg1] & ~lane_en) | (wval & lane_en)) : regs_reg[vreg1];
   assign vdata2 = hit2 ? ((regs_reg[vreg2] & ~lane_en) | (wval & lane_en)) : regs_reg[vreg2];

   // A write landing this cycle releases the consumer immediately.
   assign busy1  = pend_reg[vreg1] & ~hit1;
   assign busy2  = pend_reg[vreg2] & ~hit2;

   // Clear sequencer state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Clear sequencer next state: walk cnt over every register once, then idle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (VRFClear) begin
               state_next = CLR;
               cnt_next   = '0;
            end
         end
         CLR: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == RW'(NREGS - 1)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Register contents: clear sweep has priority, otherwise masked write.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (clearing) begin
         regs_reg[cnt_reg] <= '0;
      end else if (wr_acc) begin
         regs_reg[vregw] <= merged;
      end
   end

   // Pending bits: write clears, reserve sets afterwards so reserve wins a tie.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_reg <= '0;
      end else if (clearing) begin
         pend_reg[cnt_reg] <= 1'b0;
      end else begin
         if (wr_acc) begin
            pend_reg[vregw] <= 1'b0;
         end
         if (rsv_acc) begin
            pend_reg[vregr] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vector_regfile.sv
// Bench for vector_regfile: two instances (4x4x8 and 8x2x16) share stimulus,
// one configuration is checked per phase against a bit-level reference model.
module tb_vector_regfile;

   typedef struct {
      logic        wr;
      logic [2:0]  vregw;
      logic [31:0] dataw;
      logic [3:0]  mask;
      logic        splat;
      logic        rsv;
      logic [2:0]  vregr;
      logic [2:0]  vreg1;
      logic [2:0]  vreg2;
      logic        clr;
   } vec_t;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        b1;
      logic        b2;
      logic        clr;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  vreg1, vreg2, vregw, vregr;
   logic [31:0] vdataw;
   logic [3:0]  vmask;
   logic        VRFWrite, vsplat, VRFReserve, VRFClear;

   logic [31:0] a_d1, a_d2, b_d1, b_d2;
   logic        a_b1, a_b2, a_clr, b_b1, b_b2, b_clr;
   logic [31:0] o_d1, o_d2;
   logic        o_b1, o_b2, o_clr;

   int cfg = 0;
   int N = 4, L = 4, W = 8;
   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] m_regs [8];
   logic        m_pend [8];
   exp_t        q [$];
   vec_t        tbl [12];

   always #5 clock = ~clock;

   vector_regfile #(.NREGS(4), .LANES(4), .LW(8)) u_a (
      .clock(clock), .reset(reset),
      .vreg1(vreg1[1:0]), .vreg2(vreg2[1:0]), .vdata1(a_d1), .vdata2(a_d2),
      .vregw(vregw[1:0]), .vdataw(vdataw), .vmask(vmask), .VRFWrite(VRFWrite),
      .vsplat(vsplat), .vregr(vregr[1:0]), .VRFReserve(VRFReserve),
      .busy1(a_b1), .busy2(a_b2), .VRFClear(VRFClear), .clearing(a_clr)
   );

   vector_regfile #(.NREGS(8), .LANES(2), .LW(16)) u_b (
      .clock(clock), .reset(reset),
      .vreg1(vreg1), .vreg2(vreg2), .vdata1(b_d1), .vdata2(b_d2),
      .vregw(vregw), .vdataw(vdataw), .vmask(vmask[1:0]), .VRFWrite(VRFWrite),
      .vsplat(vsplat), .vregr(vregr), .VRFReserve(VRFReserve),
      .busy1(b_b1), .busy2(b_b2), .VRFClear(VRFClear), .clearing(b_clr)
   );

   always_comb begin
      o_d1 = a_d1; o_d2 = a_d2; o_b1 = a_b1; o_b2 = a_b2; o_clr = a_clr;
      if (cfg != 0) begin
         o_d1 = b_d1; o_d2 = b_d2; o_b1 = b_b1; o_b2 = b_b2; o_clr = b_clr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cfg%0d: got %h, expected %h", name, cfg, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic wr, input logic [2:0] w, input logic [31:0] d,
                                input logic [3:0] m, input logic s, input logic rsv,
                                input logic [2:0] r, input logic [2:0] r1,
                                input logic [2:0] r2, input logic clr);
      vec_t v;
      v.wr = wr; v.vregw = w; v.dataw = d; v.mask = m; v.splat = s;
      v.rsv = rsv; v.vregr = r; v.vreg1 = r1; v.vreg2 = r2; v.clr = clr;
      return v;
   endfunction

   function automatic logic [31:0] f_wval(input logic [31:0] d, input logic s);
      logic [31:0] r = '0;
      for (int b = 0; b < 32; b++) r[b] = s ? d[b % W] : d[b];
      return r;
   endfunction

   function automatic logic [31:0] f_en(input logic [3:0] m);
      logic [31:0] r = '0;
      for (int b = 0; b < 32; b++) r[b] = m[b / W];
      return r;
   endfunction

   function automatic logic [31:0] f_merge(input vec_t v, input logic [31:0] old);
      return (old & ~f_en(v.mask)) | (f_wval(v.dataw, v.splat) & f_en(v.mask));
   endfunction

   function automatic logic [31:0] f_read(input vec_t v, input logic [2:0] r);
      logic [31:0] val = m_regs[r];
      if (v.wr && v.vregw == r) val = f_merge(v, val);
      return val;
   endfunction

   function automatic logic f_busy(input vec_t v, input logic [2:0] r);
      return m_pend[r] && !(v.wr && v.vregw == r);
   endfunction

   task automatic idle();
      VRFWrite = 1'b0; vregw = '0; vdataw = '0; vmask = '0; vsplat = 1'b0;
      VRFReserve = 1'b0; vregr = '0; vreg1 = '0; vreg2 = '0; VRFClear = 1'b0;
   endtask

   task automatic model_zero();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endtask

   // One cycle: drive after the edge, push expectations, compare at negedge.
   task automatic step(input vec_t v);
      exp_t e;
      @(posedge clock); #1;
      VRFWrite = v.wr; vregw = v.vregw; vdataw = v.dataw; vmask = v.mask;
      vsplat = v.splat; VRFReserve = v.rsv; vregr = v.vregr;
      vreg1 = v.vreg1; vreg2 = v.vreg2; VRFClear = v.clr;
      e.d1 = f_read(v, v.vreg1); e.d2 = f_read(v, v.vreg2);
      e.b1 = f_busy(v, v.vreg1); e.b2 = f_busy(v, v.vreg2); e.clr = 1'b0;
      q.push_back(e);
      @(negedge clock);
      e = q.pop_front();
      chk("vdata1", o_d1, e.d1);
      chk("vdata2", o_d2, e.d2);
      chk("busy1", 32'(o_b1), 32'(e.b1));
      chk("busy2", 32'(o_b2), 32'(e.b2));
      chk("clearing", 32'(o_clr), 32'(e.clr));
      if (v.wr) begin
         m_regs[v.vregw] = f_merge(v, m_regs[v.vregw]);
         m_pend[v.vregw] = 1'b0;
      end
      if (v.rsv) m_pend[v.vregr] = 1'b1;
   endtask

   task automatic run_phase(input int c);
      logic [2:0]  top;
      logic [31:0] exp28, exp29;
      cfg = c;
      N = (c != 0) ? 8 : 4;
      L = (c != 0) ? 2 : 4;
      W = (c != 0) ? 16 : 8;
      top   = 3'(N - 1);
      exp28 = (c != 0) ? 32'h0000_2211 : 32'h0033_0011;
      exp29 = (c != 0) ? 32'h00AB_00AB : 32'hABAB_ABAB;

      // Reset state
      @(negedge clock); idle(); reset = 1'b0; #1;
      chk("rst_vdata1", o_d1, 32'd0);
      chk("rst_vdata2", o_d2, 32'd0);
      chk("rst_busy", 32'({o_b1, o_b2}), 32'd0);
      chk("rst_clearing", 32'(o_clr), 32'd0);
      @(negedge clock); reset = 1'b1;
      model_zero();

      // Random table
      for (int i = 0; i < 12; i++) begin
         tbl[i].wr    = 1'($urandom_range(0, 1));
         tbl[i].vregw = 3'($urandom_range(0, N - 1));
         tbl[i].dataw = $urandom;
         tbl[i].mask  = 4'($urandom);
         tbl[i].splat = 1'($urandom_range(0, 1));
         tbl[i].rsv   = 1'($urandom_range(0, 1));
         tbl[i].vregr = 3'($urandom_range(0, N - 1));
         tbl[i].vreg1 = (i % 2 == 1) ? tbl[i].vregw : 3'($urandom_range(0, N - 1));
         tbl[i].vreg2 = 3'($urandom_range(0, N - 1));
         tbl[i].clr   = 1'b0;
      end
      for (int i = 0; i < 12; i++) step(tbl[i]);

      // Masked write
      step(mkv(1'b1, 3'd2, 32'd0, 4'hF, 1'b0, 1'b0, 3'd0, 3'd2, 3'd2, 1'b0));
      step(mkv(1'b1, 3'd2, 32'h4433_2211, 4'b0101, 1'b0, 1'b0, 3'd0, 3'd2, 3'd0, 1'b0));
      step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd2, 3'd2, 1'b0));
      chk("masked_write", o_d1, exp28);

      // Splat with same-cycle bypass, then held
      step(mkv(1'b1, 3'd3, 32'h0000_00AB, 4'hF, 1'b1, 1'b0, 3'd0, 3'd3, 3'd0, 1'b0));
      chk("splat_bypass", o_d1, exp29);
      step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd3, 3'd0, 1'b0));
      chk("splat_hold", o_d1, exp29);

      // Scoreboard
      step(mkv(1'b1, 3'd1, 32'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd0, 1'b0));
      step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b1, 3'd1, 3'd1, 3'd0, 1'b0));
      step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd0, 1'b0));
      chk("busy_after_reserve", 32'(o_b1), 32'd1);
      step(mkv(1'b1, 3'd1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 3'd0, 3'd1, 3'd0, 1'b0));
      chk("busy_bypass_clear", 32'(o_b1), 32'd0);
      step(mkv(1'b1, 3'd1, 32'h0F0F_0F0F, 4'hF, 1'b0, 1'b1, 3'd1, 3'd1, 3'd0, 1'b0));
      step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd0, 1'b0));
      chk("reserve_wins", 32'(o_b1), 32'd1);

      // Bulk clear
      for (int r = 0; r < N; r++)
         step(mkv(1'b1, 3'(r), 32'(32'h1111_1111 * (r + 1)), 4'hF, 1'b0, 1'b0, 3'd0, 3'(r), top, 1'b0));
      step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b1, top, 3'd0, top, 1'b0));
      step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, top, 1'b1));
      for (int k = 0; k <= N; k++) begin
         @(posedge clock); #1; idle();
         if (k == 1) begin
            VRFWrite = 1'b1; vregw = 3'd0; vdataw = '1; vmask = 4'hF;
            VRFReserve = 1'b1; vregr = 3'd0; VRFClear = 1'b1; vreg2 = top;
         end
         @(negedge clock);
         chk("clear_window", 32'(o_clr), (k < N) ? 32'd1 : 32'd0);
         if (k == 1) begin
            chk("clear_no_bypass", o_d1, 32'd0);
            chk("clear_partial", o_d2, m_regs[top]);
            chk("clear_no_busy", 32'(o_b1), 32'd0);
         end
      end
      model_zero();
      for (int r = 0; r < N; r++) begin
         step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'(r), 3'(r), 1'b0));
         chk("cleared_reg", o_d1, 32'd0);
      end

      // Asynchronous reset in the middle of a clear
      step(mkv(1'b1, 3'd1, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0));
      step(mkv(1'b1, top, 32'h1234_5678, 4'hF, 1'b0, 1'b1, top, 3'd0, 3'd0, 1'b0));
      step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1));
      @(posedge clock); #1; idle();
      @(posedge clock); #1;
      vreg1 = top; vreg2 = 3'd1; VRFWrite = 1'b1; vregw = 3'd1;
      vdataw = 32'h5A5A_5A5A; vmask = 4'hF;
      chk("mid_clear", 32'(o_clr), 32'd1);
      #2 reset = 1'b0; #1;
      chk("arst_vdata1", o_d1, 32'd0);
      chk("arst_vdata2", o_d2, 32'd0);
      chk("arst_busy", 32'({o_b1, o_b2}), 32'd0);
      chk("arst_clearing", 32'(o_clr), 32'd0);
      @(negedge clock); #1 reset = 1'b1;
      @(posedge clock); #1; idle(); vreg1 = 3'd1;
      @(negedge clock);
      chk("post_reset_write", o_d1, 32'h5A5A_5A5A);
      chk("post_reset_idle", 32'(o_clr), 32'd0);
      model_zero();
      m_regs[1] = 32'h5A5A_5A5A;
      step(mkv(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, 3'd0, 3'd1, top, 1'b0));
   endtask

   initial begin
      idle();
      run_phase(0);
      run_phase(1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vector_regfile.md
VECTOR_REGFILE -- requirements
Module: vector_regfile

Interface
REQ-001 SHALL have parameter NREGS, default 4, meaning number of vector registers (power of 2, at least 2).
REQ-002 SHALL have parameter LANES, default 4, meaning lanes per register.
REQ-003 SHALL have parameter LW, default 8, meaning bits per lane.
REQ-004 SHALL have derived localparam RW = clog2(NREGS) and VW = LANES*LW; lane i occupies bits [i*LW +: LW].
REQ-005 SHALL have port clock  in  1  sole clock; all state changes on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports vreg1, vreg2  in  RW  read port register numbers.
REQ-008 SHALL have ports vdata1, vdata2  out  VW  read port data (combinational).
REQ-009 SHALL have ports vregw  in  RW, vdataw  in  VW, vmask  in  LANES, VRFWrite  in  1, meaning the write port; vmask bit i enables lane i.
REQ-010 SHALL have port vsplat  in  1, meaning replicate lane 0 of vdataw to all enabled lanes.
REQ-011 SHALL have ports vregr  in  RW, VRFReserve  in  1, meaning scoreboard reserve request.
REQ-012 SHALL have ports busy1, busy2  out  1, meaning the pending bit of vreg1 / vreg2.
REQ-013 SHALL have ports VRFClear  in  1, meaning start bulk clear, and clearing  out  1, meaning clear in progress.

Function
REQ-014 SHALL produce the write value per lane i as: vsplat ? vdataw lane 0 : vdataw lane i.
REQ-015 SHALL, on a clock edge with VRFWrite=1 and clearing=0, update only the lanes of register vregw whose vmask bit is 1; other lanes hold.
REQ-016 SHALL drive vdataN combinationally from register vregN, except that lanes being written this cycle (VRFWrite=1, clearing=0, vregw==vregN, vmask bit 1) SHALL show the REQ-014 value (write-through bypass, zero latency).
REQ-017 SHALL keep one pending bit per register: set on an edge with VRFReserve=1 for vregr; cleared on an edge with an accepted write to that register.
REQ-018 SHALL, for a simultaneous reserve and accepted write to the same register, leave the pending bit set (reserve wins).
REQ-019 SHALL drive busyN = pending[vregN] AND NOT (accepted write to vregN this cycle); that is, the bypass also clears busy combinationally.
REQ-020 SHALL implement a 2-state FSM, IDLE and CLR, with a RW-bit counter cnt.
REQ-021 SHALL, in IDLE with VRFClear=1, go to CLR with cnt=0 on the next edge; clearing=1 exactly while in CLR.
REQ-022 SHALL, in CLR, zero all lanes of register cnt and its pending bit on each edge, then increment cnt; after cnt=NREGS-1 it SHALL return to IDLE, so a clear takes exactly NREGS cycles.
REQ-023 SHALL ignore VRFWrite, VRFReserve and VRFClear while clearing=1; reads remain valid and show current (partially cleared) contents without bypass.
REQ-024 SHALL wrap cnt modulo NREGS; no out-of-range register access is possible.

Reset
REQ-025 SHALL, on reset low and independent of clock, zero all registers, all pending bits and cnt, and enter IDLE.
REQ-026 SHALL, with reset low, drive vdata1=vdata2=0 (except the bypass path is inactive), busy1=busy2=0, clearing=0.
REQ-027 SHALL abort any in-progress clear on reset; the first edge after release SHALL be a normal IDLE cycle.

Verification
REQ-028 SHALL verify masked write: V2=0 then write vregw=2, vdataw=0x44332211, vmask=0101 -> V2 reads 0x00330011.
REQ-029 SHALL verify splat and bypass: vsplat=1, vdataw low lane=0xAB, vmask=1111, vregw=vreg1=3 -> vdata1=0xABABABAB in the same cycle, and held after the edge.
REQ-030 SHALL verify the scoreboard: reserve V1 -> busy1=1 next cycle; the cycle of the write to V1 -> busy1=0 combinationally; a simultaneous reserve and write on V1 -> busy1 stays 1 afterwards.
REQ-031 SHALL verify bulk clear: all registers nonzero, VRFClear for 1 cycle -> clearing=1 for exactly NREGS cycles, a write issued mid-clear is dropped, and all registers read 0 afterwards.
REQ-032 SHALL verify asynchronous reset: assert reset low mid-clear between edges -> all outputs 0 immediately, clearing=0, and a normal write is accepted on the first edge after release.
REQ-033 SHALL repeat REQ-028 to REQ-031 with NREGS=8, LANES=2, LW=16.
